serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned subtractor: the inverse-direction companion to the team's adder datapath. It computes `i_a - i_b - i_bin`, one bit per clock, LSB first. Each step uses a single combinational full-subtractor cell and a borrow flip-flop. It sits behind a valid/ready input handshake and presents the parallel result on a valid/ready output handshake, for area-constrained arithmetic paths where WIDTH cycles of latency are acceptable.

## Interface
- `WIDTH`, default 8: operand and result width in bits, ≥ 2.
- `i_clk` input 1: single clock, rising edge.
- `i_rst` input 1: reset; asynchronous and active-high.
- `i_valid` input 1: operands present on `i_a`/`i_b`/`i_bin`.
- `o_ready` output 1: block can accept operands. High only in IDLE.
- `i_a` input WIDTH: minuend, unsigned.
- `i_b` input WIDTH: subtrahend, unsigned.
- `i_bin` input 1: borrow-in.
- `o_valid` output 1: result valid. High only in DONE.
- `i_ready` input 1: consumer accepts result.
- `o_diff` output WIDTH: `(i_a - i_b - i_bin) mod 2^WIDTH`.
- `o_borrow` output 1: 1 iff `i_a < i_b + i_bin`, unsigned, at full precision.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:**
  - `o_ready` = 1.
  - On an edge with `i_valid` = 1, capture `i_a` and `i_b` into shift registers and load the borrow FF with `i_bin`.
  - Clear the bit counter and go to RUN.
- **RUN:**
  - Each edge feeds the operand LSBs and the borrow FF into the full-subtractor cell.
  - The cell's difference bit shifts into the MSB of the result register; the result register shifts right.
  - The cell's borrow-out loads the borrow FF.
  - The counter increments. After the edge that processes bit WIDTH-1, go to DONE.
- **DONE:**
  - `o_valid` = 1.
  - `o_diff` and `o_borrow` (the borrow FF value) are held stable.
  - On an edge with `i_ready` = 1, go to IDLE.
- Input is ignored outside IDLE: `i_valid` in RUN/DONE has no effect, and operands are not re-sampled.
- Full-subtractor cell equations:
  - `d = a ^ b ^ bin`
  - `bout = (~a & b) | (~(a ^ b) & bin)`
- Reset, at any time including mid-RUN:
  - State goes to IDLE; the operation is abandoned with no result.
  - Counter, shift registers, result register and borrow FF clear to 0.
- Reset values: `o_ready` = 1, `o_valid` = 0, `o_diff` = 0, `o_borrow` = 0.

## Timing
- Accept edge E0 is the edge with IDLE and `i_valid` = 1. `o_ready` falls after E0.
- RUN occupies edges E1..EWIDTH. `o_valid` rises after edge EWIDTH.
- Latency: WIDTH+1 cycles from accept cycle to first `o_valid` cycle. Throughput: one operation per WIDTH+2 cycles with `i_ready` tied high.
- `o_valid` and all outputs are registered. There is no combinational path from `i_valid`/`i_ready` to any output.
- `o_valid` stays high indefinitely under backpressure. `o_diff` and `o_borrow` do not change while `o_valid` = 1.
- Completion edge: the edge with DONE and `i_ready` = 1. `o_ready` is high in the cycle after it. No accept occurs in the completion cycle itself.
- `o_diff` keeps its last value in IDLE. It is don't-care for the consumer, but it must not change until the next result.

## Structure
- Shared package `serial_arith_pkg`: state encoding localparams (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2) and the counter-width function `clog2`.
- One combinational sub-module, `full_subtractor`:
  - Ports `i_bit1`, `i_bit2`, `i_bin`, `o_diff`, `o_borrow`.
  - Built from two `half_subtractor` instances plus an OR, in keeping with the adder cell style.
  - Reusable by a future parallel ripple subtractor.
- Counter width is `clog2(WIDTH)`. The terminal count is WIDTH-1.

## Test plan
- WIDTH = 8, `i_a` = 0x35, `i_b` = 0x12, `i_bin` = 0, `i_ready` = 1 → `o_diff` = 0x23, `o_borrow` = 0; `o_valid` rises exactly 9 cycles after the accept cycle and lasts 1 cycle.
- `i_a` = 0x00, `i_b` = 0x01, `i_bin` = 0 → `o_diff` = 0xFF, `o_borrow` = 1. Also `i_a` = 0x80, `i_b` = 0x7F → 0x01, `o_borrow` = 0.
- `i_a` = 0xFF, `i_b` = 0xFF, `i_bin` = 1 → `o_diff` = 0xFF, `o_borrow` = 1. Verifies that `i_bin` is loaded into the borrow FF.
- Backpressure: hold `i_ready` = 0 for 5 cycles in DONE → `o_valid`, `o_diff` and `o_borrow` stay constant and `o_ready` stays 0. Changing `i_a`/`i_valid` during RUN does not alter the result.
- Assert `i_rst` asynchronously mid-clock at RUN bit 3 → outputs take reset values immediately without a clock edge, and no `o_valid` follows. A new operation after reset release (0x10 - 0x01 → 0x0F, `o_borrow` = 0) is correct.
- Random back-to-back operations for 1000 ops against a `{borrow, diff}` model `= {1'b0, a} - b - bin`, with random `i_valid`/`i_ready` gaps → all results match and none are dropped or duplicated.

Source files
------------

// File: rtl/serial_arith_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : serial_arith_pkg
// Brief    : Shared state encoding and helpers for the bit-serial arithmetic blocks.
// Revision : 1.0 - initial release
// ============================================================================
package serial_arith_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Never returns less than 1 so a counter declared with it always has a bit.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : half_subtractor / full_subtractor
// Brief    : Combinational subtractor cells; full cell = two half cells plus OR.
// Revision : 1.0 - initial release
// ============================================================================
module half_subtractor (
    input  logic i_bit1,
    input  logic i_bit2,
    output logic o_diff,
    output logic o_borrow
);
    assign o_diff   = i_bit1 ^ i_bit2;
    assign o_borrow = ~i_bit1 & i_bit2;
endmodule

module full_subtractor (
    input  logic i_bit1,
    input  logic i_bit2,
    input  logic i_bin,
    output logic o_diff,
    output logic o_borrow
);
    logic w_d1;
    logic w_b1;
    logic w_b2;

    half_subtractor u_hs_ab (
        .i_bit1   (i_bit1),
        .i_bit2   (i_bit2),
        .o_diff   (w_d1),
        .o_borrow (w_b1)
    );

    // Second stage borrows only when a==b and a borrow is pending.
    half_subtractor u_hs_bin (
        .i_bit1   (w_d1),
        .i_bit2   (i_bin),
        .o_diff   (o_diff),
        .o_borrow (w_b2)
    );

    assign o_borrow = w_b1 | w_b2;
endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial unsigned a - b - bin, LSB first, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);
    localparam int                CNT_W  = clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    state_t           r_state_q,  w_state_d;
    logic [WIDTH-1:0] r_a_q,      w_a_d;
    logic [WIDTH-1:0] r_b_q,      w_b_d;
    logic [WIDTH-1:0] r_diff_q,   w_diff_d;
    logic             r_borrow_q, w_borrow_d;
    logic [CNT_W-1:0] r_cnt_q,    w_cnt_d;

    logic w_cell_diff;
    logic w_cell_borrow;

    full_subtractor u_cell (
        .i_bit1   (r_a_q[0]),
        .i_bit2   (r_b_q[0]),
        .i_bin    (r_borrow_q),
        .o_diff   (w_cell_diff),
        .o_borrow (w_cell_borrow)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_a_d      = r_a_q;
        w_b_d      = r_b_q;
        w_diff_d   = r_diff_q;
        w_borrow_d = r_borrow_q;
        w_cnt_d    = r_cnt_q;
        case (r_state_q)
            IDLE: begin
                if (i_valid) begin
                    w_a_d      = i_a;
                    w_b_d      = i_b;
                    w_borrow_d = i_bin;
                    w_cnt_d    = '0;
                    w_state_d  = RUN;
                end
            end
            RUN: begin
                w_a_d      = r_a_q >> 1;
                w_b_d      = r_b_q >> 1;
                w_diff_d   = {w_cell_diff, r_diff_q[WIDTH-1:1]};
                w_borrow_d = w_cell_borrow;
                w_cnt_d    = r_cnt_q + C_ONE;
                if (r_cnt_q == C_LAST) begin
                    w_state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state_q  <= IDLE;
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_diff_q   <= '0;
            r_borrow_q <= 1'b0;
            r_cnt_q    <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_a_q      <= w_a_d;
            r_b_q      <= w_b_d;
            r_diff_q   <= w_diff_d;
            r_borrow_q <= w_borrow_d;
            r_cnt_q    <= w_cnt_d;
        end
    end

    assign o_ready  = (r_state_q == IDLE);
    assign o_valid  = (r_state_q == DONE);
    assign o_diff   = r_diff_q;
    assign o_borrow = r_borrow_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Self-checking bench: cycle-level reference model plus directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [WIDTH-1:0] i_a = '0;
    logic [WIDTH-1:0] i_b = '0;
    logic             i_bin = 1'b0;
    logic             o_valid;
    logic             i_ready = 1'b1;
    logic [WIDTH-1:0] o_diff;
    logic             o_borrow;

    int n_cmp = 0;
    int n_bad = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_bin    (i_bin),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_diff   (o_diff),
        .o_borrow (o_borrow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an operation occupies WIDTH busy cycles after acceptance,
    // then waits for the consumer; the result is plain (WIDTH+1)-bit arithmetic.
    logic [WIDTH:0] exp_q[$];
    logic           m_idle = 1'b1;
    logic           m_done = 1'b0;
    int             m_cnt  = 0;
    int             m_acc  = 0;
    int             m_cmpl = 0;
    int             dut_cmpl = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_idle <= 1'b1;
            m_done <= 1'b0;
            m_cnt  <= 0;
        end else if (m_idle) begin
            if (i_valid) begin
                exp_q.push_back({1'b0, i_a} - {1'b0, i_b} - {{WIDTH{1'b0}}, i_bin});
                m_idle <= 1'b0;
                m_cnt  <= WIDTH;
                m_acc  <= m_acc + 1;
            end
        end else if (m_cnt > 0) begin
            if (m_cnt == 1) m_done <= 1'b1;
            m_cnt <= m_cnt - 1;
        end else if (m_done && i_ready) begin
            void'(exp_q.pop_front());
            m_done <= 1'b0;
            m_idle <= 1'b1;
            m_cmpl <= m_cmpl + 1;
        end
    end

    always @(posedge clk) begin
        if (!rst && o_valid && i_ready) dut_cmpl <= dut_cmpl + 1;
    end

    always @(negedge clk) begin
        check("model o_ready", {31'd0, o_ready}, {31'd0, m_idle});
        check("model o_valid", {31'd0, o_valid}, {31'd0, m_done});
        if (m_done && exp_q.size() > 0) begin
            check("model o_diff", {24'd0, o_diff}, {24'd0, exp_q[0][WIDTH-1:0]});
            check("model o_borrow", {31'd0, o_borrow}, {31'd0, exp_q[0][WIDTH]});
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input logic [7:0] ed, input logic eb, input string nm);
        int lat;
        @(negedge clk);
        i_a = a; i_b = b; i_bin = bin; i_valid = 1'b1; i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({nm, " latency"}, lat, 9);
        check({nm, " diff"}, {24'd0, o_diff}, {24'd0, ed});
        check({nm, " borrow"}, {31'd0, o_borrow}, {31'd0, eb});
        @(negedge clk);
        check({nm, " valid one cycle"}, {31'd0, o_valid}, 32'd0);
        check({nm, " ready after"}, {31'd0, o_ready}, 32'd1);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("reset o_ready", {31'd0, o_ready}, 32'd1);
        check("reset o_valid", {31'd0, o_valid}, 32'd0);
        check("reset o_diff", {24'd0, o_diff}, 32'd0);
        check("reset o_borrow", {31'd0, o_borrow}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        run_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, "35-12");
        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "00-01");
        run_op(8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, "80-7F");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "FF-FF-1");

        // Backpressure, with operand/valid disturbance during RUN.
        @(negedge clk);
        i_a = 8'h3C; i_b = 8'h5A; i_bin = 1'b1; i_valid = 1'b1; i_ready = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            i_a = ~i_a; i_b = i_b + 8'h11; i_bin = ~i_bin; i_valid = k[0];
        end
        i_valid = 1'b0;
        begin
            int w;
            w = 0;
            while (!o_valid && w < 40) begin @(negedge clk); w++; end
        end
        for (int k = 0; k < 5; k++) begin
            check("bp valid", {31'd0, o_valid}, 32'd1);
            check("bp ready", {31'd0, o_ready}, 32'd0);
            check("bp diff", {24'd0, o_diff}, 32'hE1);
            check("bp borrow", {31'd0, o_borrow}, 32'd1);
            @(negedge clk);
        end
        i_ready = 1'b1;
        @(negedge clk);
        check("bp released", {31'd0, o_valid}, 32'd0);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        i_a = 8'hAA; i_b = 8'h55; i_bin = 1'b0; i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst o_ready", {31'd0, o_ready}, 32'd1);
        check("async rst o_valid", {31'd0, o_valid}, 32'd0);
        check("async rst o_diff", {24'd0, o_diff}, 32'd0);
        check("async rst o_borrow", {31'd0, o_borrow}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("no valid after rst", {31'd0, o_valid}, 32'd0);
        end
        run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, "10-01");

        // Random traffic with valid/ready gaps; the model checks every cycle.
        begin
            int start_cmpl;
            int cyc;
            start_cmpl = m_cmpl;
            cyc = 0;
            while (m_cmpl - start_cmpl < 1000 && cyc < 60000) begin
                @(negedge clk);
                i_valid = ($urandom_range(0, 3) != 0);
                i_ready = ($urandom_range(0, 2) != 0);
                i_a     = WIDTH'($urandom);
                i_b     = WIDTH'($urandom);
                i_bin   = 1'($urandom);
                cyc++;
            end
            check("random ops completed", (m_cmpl - start_cmpl >= 1000) ? 32'd1 : 32'd0, 32'd1);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (15) @(negedge clk);
        check("completions match", dut_cmpl, m_cmpl);
        check("no results pending", exp_q.size(), 32'd0);
        check("final idle", {31'd0, o_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
